// File: rtl/ar_pkg.sv
// Shared datapath definitions: register and bus widths, decoder vector widths
// and the decoder select indices used by the datapath registers.
package ar_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned WR_BITS = 20;
  localparam int unsigned RD_BITS = 19;

  // Decoder bit assignments; other datapath registers add their indices here.
  localparam int unsigned WR_AR     = 2;
  localparam int unsigned RD_INC_AR = 1;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [WR_BITS-1:0] wr_dec_t;
  typedef logic [RD_BITS-1:0] rd_dec_t;

endpackage : ar_pkg

// File: rtl/ar_if.sv
// Datapath control/data bundle seen by the address register: decoder vectors,
// A-bus load data and the registered address output.
interface ar_if;
  import ar_pkg::*;

  wr_dec_t WRDec_out;
  rd_dec_t RDec_out;
  word_t   A_BUS_out;
  word_t   AR_out;

  // Controller/datapath side drives decoders and A bus, observes AR.
  modport master (
    output WRDec_out,
    output RDec_out,
    output A_BUS_out,
    input  AR_out
  );

  // Register side.
  modport slave (
    input  WRDec_out,
    input  RDec_out,
    input  A_BUS_out,
    output AR_out
  );

endinterface : ar_if

// File: rtl/ar.sv
// Address register: loads from the A bus on its write-decoder select, otherwise
// increments on its read-decoder select; load has priority over increment.
module ar
  import ar_pkg::*;
#(
  parameter int unsigned WR_SEL  = WR_AR,
  parameter int unsigned INC_SEL = RD_INC_AR
) (
  input  logic Clock,
  input  logic Reset_n,
  ar_if.slave  bus
);

  word_t ar_q;
  word_t ar_d;

  // Next address: load beats increment; increment wraps modulo 2^WIDTH.
  always_comb begin
    ar_d = ar_q;
    if (bus.WRDec_out[WR_SEL]) begin
      ar_d = bus.A_BUS_out;
    end else if (bus.RDec_out[INC_SEL]) begin
      ar_d = ar_q + WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ar_q <= '0;
    end else begin
      ar_q <= ar_d;
    end
  end

  assign bus.AR_out = ar_q;

endmodule : ar

// File: tb/tb_ar.sv
// Self-checking bench for the address register: each driven cycle pushes its
// expected AR value to a scoreboard that is popped after the capturing edge.
module tb_ar;
  import ar_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ar_if bus ();

  ar dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  word_t exp_q[$];
  string tag_q[$];
  word_t model_ar;

  task automatic check_eq(input string tag, input word_t obs, input word_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic r, input wr_dec_t wr, input rd_dec_t rd,
                      input word_t a, input string tag);
    word_t got;
    @(negedge clk);
    rst_n         = r;
    bus.WRDec_out = wr;
    bus.RDec_out  = rd;
    bus.A_BUS_out = a;
    if (!r)              model_ar = 16'h0000;
    else if (wr[2])      model_ar = a;
    else if (rd[1])      model_ar = model_ar + 16'h0001;
    exp_q.push_back(model_ar);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = bus.AR_out;
    check_eq(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.WRDec_out = '0;
    bus.RDec_out  = '0;
    bus.A_BUS_out = '0;
    model_ar      = 16'h0000;

    // 1. reset overrides a pending load
    step(1'b0, 20'h00004, 19'h00000, 16'h5555, "reset");

    // 2. load then hold
    step(1'b1, 20'h00004, 19'h00000, 16'h5555, "load_5555");
    for (int i = 0; i < 3; i++)
      step(1'b1, 20'h00000, 19'h00000, 16'h0F0F, $sformatf("hold_%0d", i));

    // 3. increment twice
    step(1'b1, 20'h00000, 19'h00002, 16'h0000, "inc_5556");
    step(1'b1, 20'h00000, 19'h00002, 16'h0000, "inc_5557");

    // 4. load wins over increment, all-ones write vector still loads
    step(1'b1, 20'hFFFFF, 19'h00002, 16'h0000, "prio_load0");
    step(1'b1, 20'h00004, 19'h00000, 16'h5555, "reload_5555");

    // 5. wrap and ignored decoder bits
    step(1'b1, 20'h00004, 19'h00000, 16'hFFFF, "load_ffff");
    step(1'b1, 20'h00000, 19'h00002, 16'h0000, "wrap_0000");
    step(1'b1, 20'hFFFFB, 19'h7FFFD, 16'hBEEF, "ignored_bits");
    step(1'b1, 20'hFFFFB, 19'h00002, 16'hBEEF, "inc_other_wr");
    step(1'b1, 20'h00004, 19'h7FFFD, 16'hC3A5, "load_other_rd");

    // 6. reset mid-op beats load and increment
    step(1'b1, 20'h00004, 19'h00000, 16'h1234, "load_1234");
    step(1'b0, 20'h00004, 19'h00002, 16'hABCD, "reset_midop");
    step(1'b1, 20'h00000, 19'h00002, 16'h0000, "inc_after_rst");

    // Random mix of reset, load, increment and noise on unused bits
    for (int i = 0; i < 300; i++) begin
      logic    r;
      wr_dec_t wr;
      rd_dec_t rd;
      r  = ($urandom_range(0, 31) != 0);
      wr = wr_dec_t'($urandom());
      rd = rd_dec_t'($urandom());
      wr[2] = ($urandom_range(0, 3) == 0);
      rd[1] = ($urandom_range(0, 1) == 0);
      step(r, wr, rd, word_t'($urandom()), $sformatf("rand_%0d", i));
    end

    check_eq("scoreboard_empty", word_t'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ar

// File: doc/ar.md
# ar

Address Register (AR) of the processor datapath. Holds the 16-bit memory address presented to data memory. Loaded from the A bus when the write decoder selects it; incremented in place when the read decoder issues the AR-increment micro-operation. The registered value is continuously visible on `AR_out`.

## Interface

Parameters:
- `WIDTH`, 16, register and A-bus width.
- `WR_BITS`, 20, width of the one-hot-style write-decoder vector.
- `RD_BITS`, 19, width of the read-decoder vector.
- `WR_SEL`, 2, index of the `WRDec_out` bit that loads AR.
- `INC_SEL`, 1, index of the `RDec_out` bit that increments AR.

Ports:
- `Clock`, input, 1, system clock; all state changes on its rising edge.
- `Reset_n`, input, 1, synchronous, active-low reset.
- `WRDec_out`, input, `WR_BITS`, write-decoder outputs. Only bit `WR_SEL` is used; all other bits are ignored.
- `RDec_out`, input, `RD_BITS`, read-decoder outputs. Only bit `INC_SEL` is used; all other bits are ignored.
- `A_BUS_out`, input, `WIDTH`, A-bus value, used as the load data.
- `AR_out`, output, `WIDTH`, current AR contents, driven directly from the register.

## Operation

Evaluated at each rising edge of `Clock`, in strict priority order:

1. `Reset_n == 0`: AR <= 0.
2. `WRDec_out[WR_SEL] == 1`: AR <= `A_BUS_out`. This applies regardless of the other `WRDec_out` bits, so an all-ones vector also loads.
3. `RDec_out[INC_SEL] == 1`: AR <= AR + 1, modulo 2^WIDTH. 0xFFFF + 1 wraps to 0x0000, with no carry out.
4. Otherwise: AR holds its value.

Boundary and corner rules:
- Load and increment asserted in the same cycle: the load wins and no increment occurs.
- Reset asserted mid-sequence: it overrides any load or increment in that cycle.
- An X or Z on an unused decoder bit has no effect on AR.
- After power-up, AR is undefined until the first reset edge. The bench must reset before checking values.

## Timing

- Reset value of `AR_out`: 0x0000, visible one edge after `Reset_n` is sampled low.
- Load latency: 1 cycle. `A_BUS_out` is sampled at the edge and appears on `AR_out` immediately after that edge.
- Increment latency: 1 cycle. Each cycle with the increment bit high adds exactly 1.
- No combinational path from any input to `AR_out`.
- No handshake: decoder bits are level-sampled once per edge, and the controller holds them for one cycle per micro-operation.

## Structure

- Shared datapath package holds:
  - `WIDTH`;
  - the decoder widths (`WR_BITS` = 20, `RD_BITS` = 19);
  - named select-index constants, e.g. `WR_AR` = 2 and `RD_INC_AR` = 1.
- The package is shared with the other datapath registers, so decoder indices live in one place.
- Single flat module with one clocked process. No sub-module is warranted.

## Test plan

1. Reset: `Reset_n` = 0 for one edge with `WRDec_out` = 0x00004 and `A_BUS_out` = 0x5555 -> `AR_out` = 0x0000.
2. Load: `WRDec_out` = 0x00004, `A_BUS_out` = 0x5555 -> `AR_out` = 0x5555 after one edge. Then with `WRDec_out` = 0 and `RDec_out` = 0 -> `AR_out` holds 0x5555 over 3 edges.
3. Increment: `WRDec_out` = 0, `RDec_out` = 0x00002 -> 0x5555 becomes 0x5556 after one edge, and 0x5557 after a second edge.
4. Priority: `WRDec_out` = 0xFFFFF, `RDec_out` = 0x00002, `A_BUS_out` = 0x0000 -> `AR_out` = 0x0000, with no increment. Then `WRDec_out` = 0x00004, `RDec_out` = 0, `A_BUS_out` = 0x5555 -> `AR_out` = 0x5555.
5. Wrap and ignored bits: load 0xFFFF, then increment -> 0x0000. Then `WRDec_out` = 0xFFFFB (bit 2 clear) and `RDec_out` = 0x7FFFD (bit 1 clear) -> AR holds 0x0000.
6. Reset mid-op: AR = 0x1234, with `Reset_n` = 0 plus load 0xABCD and increment in the same cycle -> `AR_out` = 0x0000.
